fft_logpwr: RTL and testbench
=============================

FFT_LOGPWR -- requirements
Module: fft_logpwr

Interface
REQ-001 The block SHALL have parameter IW, default 16: signed width of each complex component; legal range 8..16.
REQ-002 The block SHALL have parameter OFFSET, default 0: 8-bit floor subtracted from the log code before output.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_ce, input, 1 bit: sample valid.
REQ-006 The block SHALL have port i_sync, input, 1 bit: marks the first bin of an FFT frame; qualified by i_ce.
REQ-007 The block SHALL have port i_sample, input, 2*IW bits: {real, imag}, each a two's-complement value of IW bits.
REQ-008 The block SHALL have port o_ce, output, 1 bit: pixel valid.
REQ-009 The block SHALL have port o_sync, output, 1 bit: first pixel of a frame.
REQ-010 The block SHALL have port o_pixel, output, 8 bits: log-power pixel, consumed directly by the false-colour map stage.

Function
REQ-011 The pipeline SHALL be free-running with no back-pressure: every i_ce sample produces exactly one o_ce pixel.
REQ-012 Latency SHALL be exactly 4 clocks: o_ce(t+4) = i_ce(t).
REQ-013 o_sync(t+4) SHALL equal i_sync(t) AND i_ce(t); i_sync without i_ce is ignored.
REQ-014 Stage 1 SHALL register re*re and im*im, each unsigned 2*IW bits, computed exactly; -2^(IW-1) squared gives 2^(2IW-2).
REQ-015 Stage 2 SHALL register P = re^2 + im^2, unsigned 2*IW bits, with no overflow possible (maximum 2^(2IW-1)).
REQ-016 Stage 3 SHALL register a zero flag Z = (P==0).
REQ-017 Stage 3 SHALL register E = bit index of the most significant 1 in P (0..2IW-1).
REQ-018 Stage 3 SHALL register F = the 3 bits of P immediately below bit E; positions below bit 0 read as 0.
REQ-019 Stage 4 SHALL form L = 8*E + F, 8 bits unsigned; L <= 255 is guaranteed by the IW range.
REQ-020 Stage 4 SHALL set o_pixel = 0 if Z or L <= OFFSET, else L - OFFSET.
REQ-021 o_pixel SHALL hold its last value while o_ce is low; the data registers need not be gated by the valid bits.
REQ-022 Back-to-back i_ce on consecutive clocks SHALL be supported at full rate: one pixel per clock.
REQ-023 Valid/sync flags SHALL travel in a 4-deep shift register alongside the data, one bit pair per stage.

Reset
REQ-024 i_reset SHALL force o_ce=0, o_sync=0 and o_pixel=0 on the next clock edge.
REQ-025 i_reset SHALL clear all internal valid/sync stage bits on the next clock edge.
REQ-026 Samples in flight at reset SHALL be discarded and never appear on o_ce.
REQ-027 A sample presented with i_ce in the same cycle as i_reset SHALL be discarded.
REQ-028 A sample presented on the first clock after reset deasserts SHALL be accepted and emerge 4 clocks later.
REQ-029 Data-path registers SHALL NOT be required to be reset; only the valid/sync chain and o_pixel.

Verification (IW=16, OFFSET=0 unless stated)
REQ-030 The bench SHALL drive re=0, im=0, i_ce=1 at t -> o_ce=1 at t+4, o_pixel=0x00.
REQ-031 The bench SHALL drive re=16, im=0 -> P=256, E=8, F=0, o_pixel=0x40; and re=3, im=4 -> P=25, E=4, F=4, o_pixel=0x24.
REQ-032 The bench SHALL drive re=-32768, im=-32768 -> P=2^31, o_pixel=0xF8; and re=1, im=1 -> P=2, E=1, F=0, o_pixel=0x08.
REQ-033 The bench SHALL drive 8 consecutive i_ce samples with i_sync on the first -> 8 consecutive o_ce beginning at t+4, with o_sync only on the first.
REQ-034 The bench SHALL assert i_reset for 1 clock while 3 samples are in flight -> no o_ce for those samples; o_ce, o_sync and o_pixel read 0 after the edge.
REQ-035 The bench SHALL set OFFSET=64 and drive re=16, im=0 -> o_pixel=0x00; re=256, im=0 (P=2^16, L=128) -> o_pixel=0x40.

Source files
------------

// File: rtl/fft_logpwr.sv
// Log-power pixel generator: squares each complex FFT bin and converts the power to a
// 5.3 pseudo-log code (MSB index plus three mantissa bits). Four-stage pipeline.
module fft_logpwr #(
  parameter int unsigned IW     = 16,
  parameter logic [7:0]  OFFSET = 8'd0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ce,
  input  logic            i_sync,
  input  logic [2*IW-1:0] i_sample,
  output logic            o_ce,
  output logic            o_sync,
  output logic [7:0]      o_pixel
);

  localparam int unsigned PW = 2 * IW;
  localparam int unsigned EW = $clog2(PW);

  logic [3:0] vld_q, syn_q;

  logic [PW-1:0] re_ext, im_ext;
  logic [PW-1:0] re_sq_q, im_sq_q;
  logic [PW-1:0] pwr_q;
  logic [PW+1:0] pwr_ext;
  logic          zero_d, zero_q;
  logic [EW-1:0] exp_d, exp_q;
  logic [2:0]    frac_d, frac_q;
  logic [7:0]    lcode;
  logic [7:0]    pixel_d, pixel_q;

  assign re_ext = {{IW{i_sample[PW-1]}}, i_sample[PW-1:IW]};
  assign im_ext = {{IW{i_sample[IW-1]}}, i_sample[IW-1:0]};

  // Valid/sync chain: only state that needs a reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_q <= '0;
      syn_q <= '0;
    end else begin
      vld_q <= {vld_q[2:0], i_ce};
      syn_q <= {syn_q[2:0], i_ce & i_sync};
    end
  end

  // Sign-extended operands give the exact square modulo 2^PW; the true square always fits.
  always_ff @(posedge i_clk) begin
    re_sq_q <= re_ext * re_ext;
    im_sq_q <= im_ext * im_ext;
    pwr_q   <= re_sq_q + im_sq_q;
    zero_q  <= zero_d;
    exp_q   <= exp_d;
    frac_q  <= frac_d;
  end

  // Three zero bits appended below P so the mantissa window never reads below bit 0.
  assign pwr_ext = {pwr_q[PW-2:0], 3'b000};

  always_comb begin
    zero_d = (pwr_q == '0);
    exp_d  = '0;
    frac_d = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (pwr_q[i]) begin
        exp_d  = EW'(i);
        frac_d = {pwr_ext[i+2], pwr_ext[i+1], pwr_ext[i]};
      end
    end
  end

  assign lcode = 8'({exp_q, frac_q});

  always_comb begin
    pixel_d = pixel_q;
    if (vld_q[2]) begin
      if (zero_q || (lcode <= OFFSET)) pixel_d = '0;
      else                             pixel_d = lcode - OFFSET;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) pixel_q <= '0;
    else         pixel_q <= pixel_d;
  end

  assign o_ce    = vld_q[3];
  assign o_sync  = syn_q[3];
  assign o_pixel = pixel_q;

endmodule

// File: tb/tb_fft_logpwr.sv
// Directed bench for fft_logpwr: two instances (OFFSET 0 and 64) share one stimulus stream.
module tb_fft_logpwr;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        sync;
  logic [31:0] sample;
  logic        ce0, sync0, ce1, sync1;
  logic [7:0]  pix0, pix1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_logpwr #(.IW(16), .OFFSET(8'd0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sample(sample),
    .o_ce(ce0), .o_sync(sync0), .o_pixel(pix0)
  );

  fft_logpwr #(.IW(16), .OFFSET(8'd64)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sample(sample),
    .o_ce(ce1), .o_sync(sync1), .o_pixel(pix1)
  );

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [7:0]         exp0;
    logic [7:0]         exp64;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic signed [15:0] re,
                       input logic signed [15:0] im);
    ce     = c;
    sync   = s;
    sample = {re, im};
  endtask

  initial begin
    vecs[0] = '{16'sd0,      16'sd0,      8'h00, 8'h00};
    vecs[1] = '{16'sd16,     16'sd0,      8'h40, 8'h00};
    vecs[2] = '{16'sd3,      16'sd4,      8'h24, 8'h00};
    vecs[3] = '{-16'sd32768, -16'sd32768, 8'hF8, 8'hB8};
    vecs[4] = '{16'sd1,      16'sd1,      8'h08, 8'h00};
    vecs[5] = '{16'sd256,    16'sd0,      8'h80, 8'h40};
    vecs[6] = '{16'sd32767,  16'sd0,      8'hEF, 8'hAF};
    vecs[7] = '{-16'sd1,     16'sd0,      8'h00, 8'h00};
    vecs[8] = '{16'sd100,    16'sd0,      8'h69, 8'h29};
    vecs[9] = '{16'sd0,      -16'sd3,     8'h19, 8'h00};

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'sd0, 16'sd0);
    repeat (3) @(negedge clk);
    chk("reset_ce0",   {7'd0, ce0},   8'd0);
    chk("reset_sync0", {7'd0, sync0}, 8'd0);
    chk("reset_pix0",  pix0,          8'd0);
    chk("reset_pix1",  pix1,          8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single samples: exact 4-clock latency, then the pixel holds while o_ce is low.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, vecs[i].re, vecs[i].im);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'sd0, 16'sd0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_early_ce", i), {7'd0, ce0}, 8'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_ce", i),     {7'd0, ce0},   8'd1);
      chk($sformatf("vec%0d_sync", i),   {7'd0, sync0}, 8'd0);
      chk($sformatf("vec%0d_pix0", i),   pix0, vecs[i].exp0);
      chk($sformatf("vec%0d_pix64", i),  pix1, vecs[i].exp64);
      @(negedge clk);
      chk($sformatf("vec%0d_ce_drop", i), {7'd0, ce0}, 8'd0);
      chk($sformatf("vec%0d_hold", i),    pix0, vecs[i].exp0);
    end

    // i_sync without i_ce must be ignored.
    drive(1'b0, 1'b1, 16'sd16, 16'sd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'sd0, 16'sd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("lone_sync_c%0d", c), {6'd0, sync0, ce0}, 8'd0);
    end

    // Burst of 8: re = 2^k gives P = 2^(2k), pixel = 16k.
    for (int c = 0; c < 13; c++) begin
      if (c >= 4 && c <= 11) begin
        chk($sformatf("burst_ce_c%0d", c),   {7'd0, ce0},   8'd1);
        chk($sformatf("burst_sync_c%0d", c), {7'd0, sync0}, (c == 4) ? 8'd1 : 8'd0);
        chk($sformatf("burst_pix_c%0d", c),  pix0, 8'(16 * (c - 4)));
      end else begin
        chk($sformatf("burst_idle_c%0d", c), {6'd0, sync0, ce0}, 8'd0);
      end
      if (c < 8) drive(1'b1, c == 0, 16'(1 << c), 16'sd0);
      else       drive(1'b0, 1'b0, 16'sd0, 16'sd0);
      @(negedge clk);
    end

    // Reset with 3 samples in flight, a sample during reset, and one right after.
    for (int c = 0; c < 11; c++) begin
      chk($sformatf("rst_ce_c%0d", c),   {7'd0, ce0},   (c == 8) ? 8'd1 : 8'd0);
      chk($sformatf("rst_sync_c%0d", c), {7'd0, sync0}, (c == 8) ? 8'd1 : 8'd0);
      if (c >= 4 && c <= 7) chk($sformatf("rst_pix_c%0d", c), pix0, 8'h00);
      if (c >= 8) begin
        chk($sformatf("rst_after_pix0_c%0d", c), pix0, 8'h40);
        chk($sformatf("rst_after_pix1_c%0d", c), pix1, 8'h00);
      end
      rst = (c == 3);
      if (c < 3)       drive(1'b1, 1'b1, 16'sd256, 16'sd0);
      else if (c == 3) drive(1'b1, 1'b1, 16'sd100, 16'sd0);
      else if (c == 4) drive(1'b1, 1'b1, 16'sd16, 16'sd0);
      else             drive(1'b0, 1'b0, 16'sd0, 16'sd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
